// File: rtl/seq_adder_ctrl.sv
// -----------------------------------------------------------------------------
// seq_adder_ctrl
//   Computes out = a + b + c on N = WIDTH*WORDS bit operands. It uses a single
//   WIDTH-bit adder slice, stepping through the slices one per cycle,
//   least-significant first. The carry between slices is held in a register.
//   This trades latency (WORDS cycles per operation) for a single narrow adder.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operands a, b, c presented
//   in_ready   block can accept an operation (high only in IDLE)
//   a, b       N-bit operands
//   c          carry-in
//   out_valid  result held on out (high only in DONE)
//   out_ready  consumer accepts the result
//   out        {carry_out, sum[N-1:0]}, N+1 bits
//   busy       high while an operation is in RUN or DONE
// -----------------------------------------------------------------------------

// One WIDTH-bit ripple slice: {co, s} = a + b + ci.
module adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
endmodule

module seq_adder_ctrl #(
    parameter int WIDTH = 4,
    parameter int WORDS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*WORDS-1:0] a,
    input  logic [WIDTH*WORDS-1:0] b,
    input  logic                   c,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*WORDS:0]   out,
    output logic                   busy
);
    localparam int N    = WIDTH * WORDS;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [N-1:0]     op_a;
    logic [N-1:0]     op_b;
    logic             carry;
    logic [IDXW-1:0]  idx;

    logic [WIDTH-1:0] slice_a;
    logic [WIDTH-1:0] slice_b;
    logic [WIDTH-1:0] slice_sum;
    logic             slice_co;

    // The handshake outputs decode state only, so there is no combinational
    // path from in_valid or out_ready to them.
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

    // idx never exceeds WORDS-1, so the part-selects stay in range even
    // when WORDS is not a power of two.
    always_comb begin
        slice_a = op_a[idx*WIDTH +: WIDTH];
        slice_b = op_b[idx*WIDTH +: WIDTH];
    end

    adder #(.WIDTH(WIDTH)) u_adder (
        .a  (slice_a),
        .b  (slice_b),
        .ci (carry),
        .s  (slice_sum),
        .co (slice_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            out   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        // Operands are captured here so the source may change
                        // them freely after the accept edge.
                        op_a  <= a;
                        op_b  <= b;
                        carry <= c;
                        idx   <= '0;
                        out   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    out[idx*WIDTH +: WIDTH] <= slice_sum;
                    carry                   <= slice_co;
                    if (idx == LAST_IDX) begin
                        out[N] <= slice_co;
                        state  <= S_DONE;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                S_DONE: begin
                    // The result is held until it is consumed. The return to
                    // IDLE prevents an accept in the same cycle.
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_adder_ctrl
//   Self-checking bench for seq_adder_ctrl. Three instances are used:
//     d0: WIDTH=4, WORDS=2 -- directed cases, backpressure, reset mid-RUN
//     d1: WIDTH=8, WORDS=4 -- random handshake regression against a queue
//     d2: WIDTH=8, WORDS=1 -- single-slice smoke test
// -----------------------------------------------------------------------------
module tb_seq_adder_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    // d0: WIDTH=4 WORDS=2, N=8
    logic       iv0 = 1'b0, or0 = 1'b0, c0 = 1'b0;
    logic       ir0, ov0, busy0;
    logic [7:0] a0 = '0, b0 = '0;
    logic [8:0] out0;

    // d1: WIDTH=8 WORDS=4, N=32
    logic        iv1 = 1'b0, or1 = 1'b0, c1 = 1'b0;
    logic        ir1, ov1, busy1;
    logic [31:0] a1 = '0, b1 = '0;
    logic [32:0] out1;

    // d2: WIDTH=8 WORDS=1, N=8
    logic       iv2 = 1'b0, or2 = 1'b0, c2 = 1'b0;
    logic       ir2, ov2, busy2;
    logic [7:0] a2 = '0, b2 = '0;
    logic [8:0] out2;

    seq_adder_ctrl #(.WIDTH(4), .WORDS(2)) d0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0), .c(c0),
        .out_valid(ov0), .out_ready(or0), .out(out0), .busy(busy0));

    seq_adder_ctrl #(.WIDTH(8), .WORDS(4)) d1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .c(c1),
        .out_valid(ov1), .out_ready(or1), .out(out1), .busy(busy1));

    seq_adder_ctrl #(.WIDTH(8), .WORDS(1)) d2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .c(c2),
        .out_valid(ov2), .out_ready(or2), .out(out2), .busy(busy2));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one operation on d0, and scrambles the operands right after the
    // accept. Returns the result and the number of cycles from the accept to
    // out_valid.
    task automatic run_op0(input logic [7:0] a, input logic [7:0] b, input logic c,
                           output logic [8:0] res, output int lat);
        int w = 0;
        a0 = a; b0 = b; c0 = c; iv0 = 1'b1;
        while (!ir0 && w < 20) begin tick; w++; end
        tick;                                   // accept edge
        iv0 = 1'b0;
        a0 = 8'($urandom); b0 = 8'($urandom); c0 = 1'($urandom);
        lat = 0;
        while (!ov0 && lat < 50) begin tick; lat++; end
        res = out0;
        or0 = 1'b1;
        tick;
        or0 = 1'b0;
    endtask

    initial begin
        logic [7:0]  va [3];
        logic [7:0]  vb [3];
        logic        vc [3];
        logic [8:0]  res;
        logic [8:0]  exp9;
        int          lat;
        logic        saw_ov;
        logic [32:0] q [$];
        logic [32:0] exp33;
        logic [32:0] obs33;
        logic        acc, hs, hold_req;
        int          sent, got, cyc;

        va = '{8'h3C, 8'h0F, 8'hFF};
        vb = '{8'h05, 8'h01, 8'hFF};
        vc = '{1'b0,  1'b0,  1'b1};

        // ---------------- reset state ----------------
        tick; tick;
        check("reset out",       64'(out0),  64'd0);
        check("reset out_valid", 64'(ov0),   64'd0);
        check("reset in_ready",  64'(ir0),   64'd1);
        check("reset busy",      64'(busy0), 64'd0);
        check("reset d1 valid",  64'(ov1),   64'd0);
        rst = 1'b0;
        tick;

        // ---------------- directed sums on d0 ----------------
        for (int i = 0; i < 3; i++) begin
            exp9 = 9'(va[i]) + 9'(vb[i]) + 9'(vc[i]);
            run_op0(va[i], vb[i], vc[i], res, lat);
            $display("d0 op a=0x%02h b=0x%02h c=%0d -> out=0x%03h lat=%0d", va[i], vb[i], vc[i], res, lat);
            check("d0 directed sum", 64'(res), 64'(exp9));
            check("d0 latency",      64'(lat), 64'd2);
        end

        // ---------------- backpressure on d0 ----------------
        check("bp idle ready", 64'(ir0), 64'd1);
        a0 = 8'h12; b0 = 8'h34; c0 = 1'b0; iv0 = 1'b1;
        tick;                                   // accept 0x12+0x34
        a0 = 8'hAA; b0 = 8'h11; c0 = 1'b1;      // new operands, in_valid held high
        lat = 0;
        while (!ov0 && lat < 50) begin tick; lat++; end
        check("bp latency", 64'(lat), 64'd2);
        for (int k = 0; k < 5; k++) begin
            tick;
            check("bp hold out",       64'(out0), 64'h046);
            check("bp hold out_valid", 64'(ov0),  64'd1);
            check("bp hold in_ready",  64'(ir0),  64'd0);
        end
        or0 = 1'b1;
        tick;                                   // output handshake, no accept here
        or0 = 1'b0;
        check("bp post-hs out_valid", 64'(ov0),   64'd0);
        check("bp post-hs busy",      64'(busy0), 64'd0);
        check("bp post-hs out kept",  64'(out0),  64'h046);
        tick;                                   // accept 0xAA+0x11+1 from IDLE
        iv0 = 1'b0;
        lat = 0;
        while (!ov0 && lat < 50) begin tick; lat++; end
        $display("d0 bp second op -> out=0x%03h lat=%0d", out0, lat);
        check("bp second sum",     64'(out0), 64'h0BC);
        check("bp second latency", 64'(lat),  64'd2);
        or0 = 1'b1;
        tick;
        or0 = 1'b0;

        // ---------------- reset during RUN on d0 ----------------
        a0 = 8'h77; b0 = 8'h99; c0 = 1'b1; iv0 = 1'b1;
        tick;                                   // accept, now in first RUN cycle
        iv0 = 1'b0;
        check("mid-run busy", 64'(busy0), 64'd1);
        rst = 1'b1;
        #1;
        check("rst busy",      64'(busy0), 64'd0);
        check("rst in_ready",  64'(ir0),   64'd1);
        check("rst out_valid", 64'(ov0),   64'd0);
        check("rst out",       64'(out0),  64'd0);
        tick;
        rst = 1'b0;
        saw_ov = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick;
            saw_ov = saw_ov | ov0;
        end
        check("rst no spurious valid", 64'(saw_ov), 64'd0);
        check("rst ready after",       64'(ir0),    64'd1);
        run_op0(8'h80, 8'h80, 1'b0, res, lat);
        $display("d0 post-reset op -> out=0x%03h lat=%0d", res, lat);
        check("post-reset sum", 64'(res), 64'h100);

        // ---------------- WORDS=1 smoke on d2 ----------------
        for (int i = 0; i < 8; i++) begin
            a2 = 8'($urandom); b2 = 8'($urandom); c2 = 1'($urandom);
            exp9 = 9'(a2) + 9'(b2) + 9'(c2);
            check("d2 ready", 64'(ir2), 64'd1);
            iv2 = 1'b1;
            tick;                               // accept
            iv2 = 1'b0;
            a2 = 8'($urandom); b2 = 8'($urandom);
            tick;                               // single RUN cycle
            $display("d2 op -> out=0x%03h expected 0x%03h", out2, exp9);
            check("d2 valid", 64'(ov2),  64'd1);
            check("d2 sum",   64'(out2), 64'(exp9));
            or2 = 1'b1;
            tick;
            or2 = 1'b0;
        end

        // ---------------- random regression on d1 ----------------
        sent = 0; got = 0; cyc = 0;
        while (got < 1000 && cyc < 60000) begin
            iv1 = (sent < 1000) && 1'($urandom);
            a1  = $urandom;
            b1  = $urandom;
            c1  = 1'($urandom);
            or1 = ($urandom_range(0, 3) != 0);
            // ready/valid are registered decodes, so they predict the next edge.
            acc      = iv1 && ir1;
            hs       = ov1 && or1;
            hold_req = ov1 && !or1;
            obs33    = out1;
            exp33    = 33'(a1) + 33'(b1) + 33'(c1);
            tick;
            cyc++;
            if (acc) begin
                q.push_back(exp33);
                sent++;
            end
            if (hold_req) check("d1 valid held", 64'(ov1), 64'd1);
            if (hs) begin
                if (q.size() == 0) begin
                    check("d1 unexpected output", 64'(obs33), 64'h1_0000_0000_0000);
                end else begin
                    exp33 = q.pop_front();
                    $display("d1 op %0d -> out=0x%09h expected 0x%09h", got, obs33, exp33);
                    check("d1 sum", 64'(obs33), 64'(exp33));
                end
                got++;
            end
        end
        iv1 = 1'b0;
        or1 = 1'b0;
        check("d1 results received", 64'(got),      64'd1000);
        check("d1 queue drained",    64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
